// File: rtl/tl_ul_pkg.sv
`default_nettype none
// ============================================================================
//  tl_ul_pkg
//  TileLink-UL opcodes, D-channel response record and opcode legality helper.
//  Revision: 1.0
// ============================================================================
package tl_ul_pkg;

    localparam int TL_SRC_W  = 10;
    localparam int TL_DATA_W = 32;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [1:0]           size;
        logic [TL_SRC_W-1:0]  source;
        logic                 denied;
        logic [TL_DATA_W-1:0] data;
        logic                 corrupt;
    } tl_d_resp_t;

    function automatic logic is_legal_opcode(input logic [2:0] op);
        return (op == PUT_FULL) || (op == PUT_PARTIAL) || (op == GET);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_1rw.sv
`default_nettype none
// ============================================================================
//  sram_1rw
//  Single-port SRAM: byte-enable write, registered 1-cycle read, no reset.
//  Revision: 1.0
// ============================================================================
module sram_1rw #(
    parameter int WORDS  = 4096,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       i_en,
    input  logic                       i_we,
    input  logic [DATA_W/8-1:0]        i_be,
    input  logic [$clog2(WORDS)-1:0]   i_idx,
    input  logic [DATA_W-1:0]          i_wdata,
    output logic [DATA_W-1:0]          o_rdata
);

    logic [DATA_W-1:0] r_mem [WORDS];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < DATA_W/8; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_idx];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/tl_ul_sram_slave.sv
`default_nettype none
// ============================================================================
//  tl_ul_sram_slave
//  Single-beat TileLink-UL SRAM slave: decode, S1 stage, response FIFO, credits.
//  Revision: 1.0
// ============================================================================
module tl_ul_sram_slave #(
    parameter int                ADDR_W     = 17,
    parameter int                SRC_W      = 10,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                MEM_WORDS  = 4096,
    parameter int                RESP_DEPTH = 3
) (
    input  logic                clock,
    input  logic                reset,
    output logic                a_ready,
    input  logic                a_valid,
    input  logic [2:0]          a_bits_opcode,
    input  logic [2:0]          a_bits_param,
    input  logic [1:0]          a_bits_size,
    input  logic [SRC_W-1:0]    a_bits_source,
    input  logic [ADDR_W-1:0]   a_bits_address,
    input  logic [DATA_W/8-1:0] a_bits_mask,
    input  logic [DATA_W-1:0]   a_bits_data,
    input  logic                a_bits_corrupt,
    input  logic                d_ready,
    output logic                d_valid,
    output logic [2:0]          d_bits_opcode,
    output logic [1:0]          d_bits_size,
    output logic [SRC_W-1:0]    d_bits_source,
    output logic                d_bits_denied,
    output logic [DATA_W-1:0]   d_bits_data,
    output logic                d_bits_corrupt
);

    import tl_ul_pkg::*;

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [32:0]      c_BASE  = 33'(BASE_ADDR);
    localparam logic [32:0]      c_SPAN  = 33'(MEM_WORDS) * 33'd4;
    localparam logic [CNT_W:0]   c_DEPTH = (CNT_W + 1)'(RESP_DEPTH);
    localparam logic [PTR_W-1:0] c_LAST  = PTR_W'(RESP_DEPTH - 1);

    logic              w_fire, w_is_get, w_in_range, w_aligned, w_denied, w_sram_en;
    logic [32:0]       w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rdata;
    logic              w_enq, w_deq;
    logic [CNT_W:0]    w_occ;
    tl_d_resp_t        w_enq_resp, w_head;

    logic              r_ready_en, r_s1_valid, r_s1_rd;
    tl_d_resp_t        r_s1_resp;
    tl_d_resp_t        r_q [RESP_DEPTH];
    logic [PTR_W-1:0]  r_wptr, r_rptr;
    logic [CNT_W-1:0]  r_count;

    // Addresses below BASE wrap to a huge offset, so one compare covers both ends.
    assign w_off      = 33'(a_bits_address) - c_BASE;
    assign w_in_range = w_off < c_SPAN;
    assign w_idx      = w_off[IDX_W+1:2];

    // size 3 is never aligned, which folds the illegal-size check in here.
    always_comb begin
        w_aligned = 1'b0;
        case (a_bits_size)
            2'd0:    w_aligned = 1'b1;
            2'd1:    w_aligned = ~a_bits_address[0];
            2'd2:    w_aligned = (a_bits_address[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    assign w_fire    = a_valid & a_ready;
    assign w_is_get  = (a_bits_opcode == GET);
    assign w_denied  = ~w_in_range | ~is_legal_opcode(a_bits_opcode) | ~w_aligned;
    assign w_sram_en = w_fire & ~w_denied;

    sram_1rw #(
        .WORDS  (MEM_WORDS),
        .DATA_W (DATA_W)
    ) u_sram (
        .clk     (clock),
        .i_en    (w_sram_en),
        .i_we    (~w_is_get),
        .i_be    (a_bits_mask),
        .i_idx   (w_idx),
        .i_wdata (a_bits_data),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ready_en <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_rd    <= 1'b0;
            r_s1_resp  <= '0;
        end else begin
            r_ready_en <= 1'b1;
            r_s1_valid <= w_fire;
            if (w_fire) begin
                r_s1_resp.opcode  <= w_is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
                r_s1_resp.size    <= a_bits_size;
                r_s1_resp.source  <= a_bits_source;
                r_s1_resp.denied  <= w_denied;
                r_s1_resp.data    <= '0;
                r_s1_resp.corrupt <= w_is_get & w_denied;
                r_s1_rd           <= w_is_get & ~w_denied;
            end
        end
    end

    // SRAM read data lands the cycle after the access, alongside S1.
    always_comb begin
        w_enq_resp = r_s1_resp;
        if (r_s1_rd) begin
            w_enq_resp.data = w_rdata;
        end
    end

    assign w_enq = r_s1_valid;
    assign w_deq = d_valid & d_ready;

    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_q[r_wptr] <= w_enq_resp;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_deq) begin
                r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Credit counts the S1 entry as already owning a queue slot.
    assign w_occ   = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_valid};
    assign a_ready = r_ready_en & (w_occ < c_DEPTH);

    assign d_valid        = (r_count != '0);
    assign w_head         = d_valid ? r_q[r_rptr] : '0;
    assign d_bits_opcode  = w_head.opcode;
    assign d_bits_size    = w_head.size;
    assign d_bits_source  = w_head.source;
    assign d_bits_denied  = w_head.denied;
    assign d_bits_data    = w_head.data;
    assign d_bits_corrupt = w_head.corrupt;

    logic w_unused;
    assign w_unused = ^{a_bits_param, a_bits_corrupt, w_off[1:0], w_off[32:IDX_W+2]};

endmodule
`default_nettype wire

// File: tb/tb_tl_ul_sram_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  tb_tl_ul_sram_slave
//  Directed and random stimulus against a transaction-level memory model.
//  Revision: 1.0
// ============================================================================
module tb_tl_ul_sram_slave;

    localparam int          MEM_WORDS = 4096;
    localparam longint      BASE      = 0;
    localparam longint      LIMIT     = BASE + MEM_WORDS * 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        a_ready, a_valid;
    logic [2:0]  a_op, a_param;
    logic [1:0]  a_size;
    logic [9:0]  a_src;
    logic [16:0] a_addr;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        d_ready, d_valid;
    logic [2:0]  d_op;
    logic [1:0]  d_size;
    logic [9:0]  d_src;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;

    always #5 clock = ~clock;

    tl_ul_sram_slave dut (
        .clock          (clock),
        .reset          (reset),
        .a_ready        (a_ready),
        .a_valid        (a_valid),
        .a_bits_opcode  (a_op),
        .a_bits_param   (a_param),
        .a_bits_size    (a_size),
        .a_bits_source  (a_src),
        .a_bits_address (a_addr),
        .a_bits_mask    (a_mask),
        .a_bits_data    (a_data),
        .a_bits_corrupt (a_corrupt),
        .d_ready        (d_ready),
        .d_valid        (d_valid),
        .d_bits_opcode  (d_op),
        .d_bits_size    (d_size),
        .d_bits_source  (d_src),
        .d_bits_denied  (d_denied),
        .d_bits_data    (d_data),
        .d_bits_corrupt (d_corrupt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [9:0]  src;
        logic        denied;
        logic [31:0] data;
        logic [3:0]  known;
        logic        corrupt;
        int          cyc;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] m_mem [MEM_WORDS];
    logic [3:0]  m_kn  [MEM_WORDS];
    int          cyc = 0;
    bit          lat_exact = 0;
    bit          last_fired = 0;
    bit          stall_prev = 0;
    logic [63:0] stall_bits;
    logic [31:0] last_data;
    logic        last_denied, last_corrupt;
    logic [2:0]  last_op;

    // Reference: every accepted request takes effect on memory in acceptance order.
    task automatic model_accept();
        exp_t   e;
        longint a     = longint'(a_addr);
        longint bytes = longint'(1) << a_size;
        bit     legal = (a_op == 3'd0) || (a_op == 3'd1) || (a_op == 3'd4);
        bit     get   = (a_op == 3'd4);
        int     idx;
        e.denied = !legal || (a_size == 2'd3) || ((a % bytes) != 0) || (a < BASE) || (a >= LIMIT);
        idx      = int'((a - BASE) / 4) % MEM_WORDS;
        if (!e.denied && !get) begin
            for (int b = 0; b < 4; b++) begin
                if (a_mask[b]) begin
                    m_mem[idx][8*b +: 8] = a_data[8*b +: 8];
                    m_kn[idx][b] = 1'b1;
                end
            end
        end
        e.op      = get ? 3'd1 : 3'd0;
        e.size    = a_size;
        e.src     = a_src;
        e.corrupt = get && e.denied;
        e.data    = (get && !e.denied) ? m_mem[idx] : 32'h0;
        e.known   = (get && !e.denied) ? m_kn[idx] : 4'hF;
        e.cyc     = cyc;
        expq.push_back(e);
    endtask

    // Evaluate the handshakes that the coming rising edge will perform, then advance.
    task automatic step();
        exp_t        e;
        logic [31:0] km;
        logic [63:0] cur;
        cur = {15'h0, d_op, d_size, d_src, d_denied, d_data, d_corrupt};
        if (stall_prev) begin
            check("d_hold_valid", 64'(d_valid), 64'd1);
            check("d_hold_bits", cur, stall_bits);
        end
        if (d_valid && d_ready) begin
            if (expq.size() == 0) begin
                check("unexpected_resp", 64'd1, 64'd0);
            end else begin
                e = expq.pop_front();
                for (int b = 0; b < 4; b++) km[8*b +: 8] = {8{e.known[b]}};
                check("d_opcode", 64'(d_op), 64'(e.op));
                check("d_size", 64'(d_size), 64'(e.size));
                check("d_source", 64'(d_src), 64'(e.src));
                check("d_denied", 64'(d_denied), 64'(e.denied));
                check("d_corrupt", 64'(d_corrupt), 64'(e.corrupt));
                check("d_data", 64'(d_data & km), 64'(e.data & km));
                if (lat_exact) check("latency", 64'(cyc - e.cyc), 64'd2);
            end
            last_data    = d_data;
            last_denied  = d_denied;
            last_corrupt = d_corrupt;
            last_op      = d_op;
        end
        last_fired = a_valid && a_ready;
        if (last_fired) model_accept();
        stall_prev = d_valid && !d_ready;
        stall_bits = cur;
        @(negedge clock);
        cyc++;
    endtask

    task automatic send(input logic [2:0] op, input logic [1:0] size, input logic [9:0] src,
                        input logic [16:0] addr, input logic [3:0] mask, input logic [31:0] data);
        int n = 0;
        a_valid = 1'b1; a_op = op; a_size = size; a_src = src;
        a_addr = addr; a_mask = mask; a_data = data; a_corrupt = 1'b0;
        while (!a_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("a_ready_timeout", 64'd1, 64'd0);
        step();
        a_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        a_valid = 1'b0;
        d_ready = 1'b1;
        while ((expq.size() != 0 || d_valid) && n < 60) begin
            step();
            n++;
        end
        check("drain_empty", 64'(expq.size()), 64'd0);
    endtask

    task automatic rand_req();
        int r;
        r = $urandom_range(0, 9);
        a_op = (r < 2) ? 3'd0 : (r < 4) ? 3'd1 : (r < 8) ? 3'd4 : (r == 8) ? 3'd2 : 3'd7;
        r = $urandom_range(0, 9);
        a_size = (r < 6) ? 2'd2 : (r == 6) ? 2'd0 : (r == 7) ? 2'd1 : 2'd3;
        r = $urandom_range(0, 9);
        if (r < 7) begin
            a_addr = 17'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 4) == 0) a_addr = a_addr + 17'($urandom_range(1, 3));
        end else if (r < 9) begin
            a_addr = 17'(LIMIT - 4 * $urandom_range(0, 1) + 4 * $urandom_range(0, 1));
        end else begin
            a_addr = 17'($urandom_range(0, 17'h1FFFF));
        end
        a_src     = 10'($urandom_range(0, 1023));
        a_mask    = 4'($urandom_range(0, 15));
        a_data    = $urandom;
        a_corrupt = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fires;
        int n;
        for (int i = 0; i < MEM_WORDS; i++) m_kn[i] = 4'h0;
        a_valid = 1'b0; a_op = 3'd0; a_param = 3'd0; a_size = 2'd0; a_src = '0;
        a_addr = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0; d_ready = 1'b0;

        repeat (3) @(negedge clock);
        check("reset_a_ready", 64'(a_ready), 64'd0);
        check("reset_d_valid", 64'(d_valid), 64'd0);
        check("reset_d_bits", {15'h0, d_op, d_size, d_src, d_denied, d_data, d_corrupt}, 64'd0);
        reset = 1'b1;
        check("a_ready_before_edge", 64'(a_ready), 64'd0);
        step();
        check("a_ready_after_release", 64'(a_ready), 64'd1);

        // Write, then read back on the very next cycle.
        d_ready = 1'b1;
        send(3'd0, 2'd2, 10'd5, 17'h10, 4'hF, 32'hDEADBEEF);
        send(3'd4, 2'd2, 10'd6, 17'h10, 4'hF, 32'h0);
        drain();
        check("raw_data", 64'(last_data), 64'hDEADBEEF);
        check("raw_opcode", 64'(last_op), 64'd1);

        send(3'd1, 2'd2, 10'd7, 17'h10, 4'b0010, 32'h0000AA00);
        send(3'd4, 2'd2, 10'd8, 17'h10, 4'hF, 32'h0);
        drain();
        check("partial_data", 64'(last_data), 64'hDEADAAEF);

        // Out of range: denied Get, and a denied Put whose index would alias word 4.
        send(3'd4, 2'd2, 10'd9, 17'(LIMIT), 4'hF, 32'h0);
        drain();
        check("oor_get_denied", 64'(last_denied), 64'd1);
        check("oor_get_corrupt", 64'(last_corrupt), 64'd1);
        check("oor_get_data", 64'(last_data), 64'd0);
        send(3'd0, 2'd2, 10'd10, 17'(LIMIT + 'h10), 4'hF, 32'h12345678);
        send(3'd4, 2'd2, 10'd11, 17'h10, 4'hF, 32'h0);
        drain();
        check("oor_put_no_write", 64'(last_data), 64'hDEADAAEF);

        // Stalled D channel: only RESP_DEPTH requests may be accepted.
        d_ready = 1'b0;
        fires = 0;
        a_valid = 1'b1; a_op = 3'd4; a_size = 2'd2; a_addr = 17'h10; a_src = 10'd20;
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_fired) begin
                fires++;
                a_src = a_src + 10'd1;
            end
        end
        check("stall_accepted", 64'(fires), 64'd3);
        check("stall_a_ready", 64'(a_ready), 64'd0);
        d_ready = 1'b1;
        while (fires < 5) begin
            send(3'd4, 2'd2, a_src, 17'h10, 4'hF, 32'h0);
            fires++;
            a_src = a_src + 10'd1;
        end
        drain();

        // Sustained throughput with fixed two-cycle latency.
        lat_exact = 1'b1;
        fires = 0;
        a_valid = 1'b1; a_op = 3'd4; a_size = 2'd2;
        for (int i = 0; i < 20; i++) begin
            a_addr = 17'((i % 8) * 4);
            a_src  = 10'(100 + i);
            step();
            if (last_fired) fires++;
        end
        check("throughput_fires", 64'(fires), 64'd20);
        drain();
        lat_exact = 1'b0;

        // Asynchronous reset with two responses queued.
        d_ready = 1'b0;
        send(3'd4, 2'd2, 10'd30, 17'h10, 4'hF, 32'h0);
        send(3'd4, 2'd2, 10'd31, 17'h10, 4'hF, 32'h0);
        step();
        step();
        check("queued_before_reset", 64'(d_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async_d_valid", 64'(d_valid), 64'd0);
        check("async_a_ready", 64'(a_ready), 64'd0);
        expq.delete();
        stall_prev = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        step();
        check("ready_after_reset2", 64'(a_ready), 64'd1);
        d_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (d_valid) n++;
            step();
        end
        check("no_stale_resp", 64'(n), 64'd0);
        send(3'd4, 2'd2, 10'd32, 17'h10, 4'hF, 32'h0);
        drain();
        check("sram_kept", 64'(last_data), 64'hDEADAAEF);

        // Random traffic with random back-pressure.
        a_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!a_valid && $urandom_range(0, 3) != 0) begin
                rand_req();
                a_valid = 1'b1;
            end
            d_ready = ($urandom_range(0, 3) != 0);
            step();
            if (last_fired) a_valid = 1'b0;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
